// File: rtl/common_serial_decr_timer_if.sv
// Load/tick/status bundle for common_serial_decr_timer; master drives requests, slave is the timer.
interface common_serial_decr_timer_if #(
    parameter int unsigned NIBBLES = 4
);
    logic                   i_abort;
    logic                   i_load_valid;
    logic                   o_load_ready;
    logic [4*NIBBLES-1:0]   i_load_value;
    logic                   i_tick;
    logic [4*NIBBLES-1:0]   o_count;
    logic                   o_busy;
    logic                   o_armed;
    logic                   o_expire;
    logic                   o_tick_drop;

    modport master (
        output i_abort, i_load_valid, i_load_value, i_tick,
        input  o_load_ready, o_count, o_busy, o_armed, o_expire, o_tick_drop
    );

    modport slave (
        input  i_abort, i_load_valid, i_load_value, i_tick,
        output o_load_ready, o_count, o_busy, o_armed, o_expire, o_tick_drop
    );
endinterface

// File: rtl/common_serial_decr_timer.sv
// Multi-nibble down-counter that ripples a single 4-bit decrement ROM across the
// count one nibble per cycle, LSB first, stopping as soon as no borrow remains.
module common_rtlrom_decr4 (
    input  logic [3:0] i_d,
    output logic [3:0] o_q,
    output logic       o_c
);
    always_comb begin
        o_q = 4'h0;
        o_c = 1'b0;
        unique case (i_d)
            4'h0: begin o_q = 4'hF; o_c = 1'b1; end
            4'h1: o_q = 4'h0;
            4'h2: o_q = 4'h1;
            4'h3: o_q = 4'h2;
            4'h4: o_q = 4'h3;
            4'h5: o_q = 4'h4;
            4'h6: o_q = 4'h5;
            4'h7: o_q = 4'h6;
            4'h8: o_q = 4'h7;
            4'h9: o_q = 4'h8;
            4'hA: o_q = 4'h9;
            4'hB: o_q = 4'hA;
            4'hC: o_q = 4'hB;
            4'hD: o_q = 4'hC;
            4'hE: o_q = 4'hD;
            4'hF: o_q = 4'hE;
            default: begin o_q = 4'h0; o_c = 1'b0; end
        endcase
    end
endmodule

module common_serial_decr_timer #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    common_serial_decr_timer_if.slave  bus
);
    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_STEP  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           pending_q, pending_d;
    logic           expire_q, expire_d;
    logic           drop_q, drop_d;

    logic [3:0]     rom_d;
    logic [3:0]     rom_q;
    logic           rom_c;

    assign rom_d = count_q[4*idx_q +: 4];

    common_rtlrom_decr4 u_rom (
        .i_d (rom_d),
        .o_q (rom_q),
        .o_c (rom_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
            expire_q  <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            expire_q  <= expire_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        expire_d  = 1'b0;
        drop_d    = 1'b0;
        if (bus.i_abort) begin
            state_d   = S_IDLE;
            count_d   = '0;
            pending_d = 1'b0;
            idx_d     = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_ARMED: begin
                    if (bus.i_load_valid) begin
                        count_d = bus.i_load_value;
                        state_d = (bus.i_load_value != '0) ? S_ARMED : S_IDLE;
                    end else if (state_q == S_ARMED && bus.i_tick) begin
                        state_d = S_STEP;
                        idx_d   = '0;
                    end
                end
                S_STEP: begin
                    count_d[4*idx_q +: 4] = rom_q;
                    // A tick on the completing edge still lands in the pending slot,
                    // so it is served by the restart below rather than being lost.
                    if (bus.i_tick) begin
                        if (pending_q) drop_d    = 1'b1;
                        else           pending_d = 1'b1;
                    end
                    if (rom_c && idx_q != IDX_LAST) begin
                        idx_d = idx_q + IW'(1);
                    end else if (count_d == '0) begin
                        expire_d  = 1'b1;
                        state_d   = S_IDLE;
                        pending_d = 1'b0;
                        idx_d     = '0;
                    end else if (pending_q || bus.i_tick) begin
                        pending_d = 1'b0;
                        idx_d     = '0;
                    end else begin
                        state_d = S_ARMED;
                        idx_d   = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.o_load_ready = (state_q != S_STEP);
    assign bus.o_count      = count_q;
    assign bus.o_busy       = (state_q == S_STEP);
    assign bus.o_armed      = (state_q == S_ARMED);
    assign bus.o_expire     = expire_q;
    assign bus.o_tick_drop  = drop_q;
endmodule

// File: tb/tb_common_serial_decr_timer.sv
// Bench for common_serial_decr_timer: directed vector table, hand-written corner
// sequences and random traffic, all compared against a cycle-level behavioural model.
module tb_common_serial_decr_timer;
    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W = 4 * NIBBLES;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    common_serial_decr_timer_if #(.NIBBLES(NIBBLES)) bus ();

    common_serial_decr_timer #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: 0 idle, 1 armed, 2 busy; a step lasts 1 + trailing zero nibbles.
    int unsigned  m_st;
    logic [W-1:0] m_cnt, m_tgt;
    int           m_rem;
    bit           m_pend, m_exp, m_drop;
    int           busy_n, drop_n, exp_n;

    function automatic int step_len(logic [W-1:0] v);
        int n = 1;
        for (int i = 0; i < int'(NIBBLES) - 1; i++) begin
            if (v[4*i +: 4] != 4'h0) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        m_st = 0; m_cnt = '0; m_tgt = '0; m_rem = 0;
        m_pend = 0; m_exp = 0; m_drop = 0;
    endtask

    task automatic model_edge(input bit a, input bit lv, input logic [W-1:0] v, input bit t);
        m_exp = 0; m_drop = 0;
        if (a) begin
            m_st = 0; m_cnt = '0; m_pend = 0;
        end else if (m_st == 2) begin
            if (t) begin
                if (m_pend) m_drop = 1;
                else        m_pend = 1;
            end
            m_rem--;
            if (m_rem == 0) begin
                m_cnt = m_tgt;
                if (m_cnt == '0) begin
                    m_exp = 1; m_st = 0; m_pend = 0;
                end else if (m_pend) begin
                    m_pend = 0; m_tgt = m_cnt - 1'b1; m_rem = step_len(m_cnt);
                end else begin
                    m_st = 1;
                end
            end
        end else if (lv) begin
            m_cnt = v;
            m_st  = (v != '0) ? 1 : 0;
        end else if (m_st == 1 && t) begin
            m_st = 2; m_tgt = m_cnt - 1'b1; m_rem = step_len(m_cnt);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("busy", 32'(bus.o_busy), 32'(m_st == 2));
        chk("armed", 32'(bus.o_armed), 32'(m_st == 1));
        chk("load_ready", 32'(bus.o_load_ready), 32'(m_st != 2));
        chk("expire", 32'(bus.o_expire), 32'(m_exp));
        chk("tick_drop", 32'(bus.o_tick_drop), 32'(m_drop));
        if (m_st != 2) chk("count", 32'(bus.o_count), 32'(m_cnt));
    endtask

    // Called at a negedge: drive inputs, let the edge happen, then check at the next negedge.
    task automatic step(input bit a, input bit lv, input logic [W-1:0] v, input bit t);
        bus.i_abort      = a;
        bus.i_load_valid = lv;
        bus.i_load_value = v;
        bus.i_tick       = t;
        @(posedge clk);
        model_edge(a, lv, v, t);
        @(negedge clk);
        compare_model();
        if (bus.o_busy)      busy_n++;
        if (bus.o_tick_drop) drop_n++;
        if (bus.o_expire)    exp_n++;
    endtask

    always @(negedge clk) begin
        if (!reset && bus.o_busy && dut.rom_c && dut.idx_q == NIBBLES - 1) begin
            errors++;
            $display("FAIL borrow_out_of_msb: borrow seen at nibble %0d expected none", dut.idx_q);
        end
    end

    typedef struct {
        bit           ab;
        bit           lv;
        logic [W-1:0] val;
        bit           tk;
        bit           busy;
        bit           armed;
        bit           ck_cnt;
        logic [W-1:0] cnt;
        bit           expire;
        bit           drop;
    } vec_t;

    vec_t tbl [17];

    initial begin
        // load 0x0100, tick: three busy cycles, ends at 0x00FF
        tbl[0]  = '{0, 1, 16'h0100, 0,  0, 1, 1, 16'h0100, 0, 0};
        tbl[1]  = '{0, 0, 16'h0000, 1,  1, 0, 0, 16'h0000, 0, 0};
        tbl[2]  = '{0, 0, 16'h0000, 0,  1, 0, 0, 16'h0000, 0, 0};
        tbl[3]  = '{0, 0, 16'h0000, 0,  1, 0, 0, 16'h0000, 0, 0};
        tbl[4]  = '{0, 0, 16'h0000, 0,  0, 1, 1, 16'h00FF, 0, 0};
        // load 0x0001, tick: one busy cycle then a single expire pulse
        tbl[5]  = '{0, 1, 16'h0001, 0,  0, 1, 1, 16'h0001, 0, 0};
        tbl[6]  = '{0, 0, 16'h0000, 1,  1, 0, 0, 16'h0000, 0, 0};
        tbl[7]  = '{0, 0, 16'h0000, 0,  0, 0, 1, 16'h0000, 1, 0};
        tbl[8]  = '{0, 0, 16'h0000, 0,  0, 0, 1, 16'h0000, 0, 0};
        // abort in the second STEP cycle, zero load, ignored ticks
        tbl[9]  = '{0, 1, 16'h0100, 0,  0, 1, 1, 16'h0100, 0, 0};
        tbl[10] = '{0, 0, 16'h0000, 1,  1, 0, 0, 16'h0000, 0, 0};
        tbl[11] = '{0, 0, 16'h0000, 0,  1, 0, 0, 16'h0000, 0, 0};
        tbl[12] = '{1, 0, 16'h0000, 0,  0, 0, 1, 16'h0000, 0, 0};
        tbl[13] = '{0, 0, 16'h0000, 0,  0, 0, 1, 16'h0000, 0, 0};
        tbl[14] = '{0, 1, 16'h0000, 1,  0, 0, 1, 16'h0000, 0, 0};
        tbl[15] = '{0, 0, 16'h0000, 1,  0, 0, 1, 16'h0000, 0, 0};
        tbl[16] = '{0, 0, 16'h0000, 1,  0, 0, 1, 16'h0000, 0, 0};

        reset = 1'b1;
        bus.i_abort = 1'b0; bus.i_load_valid = 1'b0; bus.i_load_value = '0; bus.i_tick = 1'b0;
        busy_n = 0; drop_n = 0; exp_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(bus.o_busy), 32'd0);
        chk("reset_armed", 32'(bus.o_armed), 32'd0);
        chk("reset_count", 32'(bus.o_count), 32'd0);
        chk("reset_expire", 32'(bus.o_expire), 32'd0);
        chk("reset_drop", 32'(bus.o_tick_drop), 32'd0);
        chk("reset_ready", 32'(bus.o_load_ready), 32'd1);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].ab, tbl[i].lv, tbl[i].val, tbl[i].tk);
            chk($sformatf("vec%0d_busy", i), 32'(bus.o_busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d_armed", i), 32'(bus.o_armed), 32'(tbl[i].armed));
            chk($sformatf("vec%0d_expire", i), 32'(bus.o_expire), 32'(tbl[i].expire));
            chk($sformatf("vec%0d_drop", i), 32'(bus.o_tick_drop), 32'(tbl[i].drop));
            if (tbl[i].ck_cnt) chk($sformatf("vec%0d_count", i), 32'(bus.o_count), 32'(tbl[i].cnt));
        end

        // pending tick served back-to-back
        step(0, 1, 16'h1000, 0);
        busy_n = 0; drop_n = 0; exp_n = 0;
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        repeat (6) step(0, 0, '0, 0);
        chk("pend_busy_cycles", busy_n, 5);
        chk("pend_drops", drop_n, 0);
        chk("pend_count", 32'(bus.o_count), 32'h0FFE);
        chk("pend_expires", exp_n, 0);

        // third tick overflows the pending slot
        step(0, 1, 16'h1000, 0);
        busy_n = 0; drop_n = 0; exp_n = 0;
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        repeat (5) step(0, 0, '0, 0);
        chk("drop_busy_cycles", busy_n, 5);
        chk("drop_pulses", drop_n, 1);
        chk("drop_count", 32'(bus.o_count), 32'h0FFE);

        // asynchronous reset in the middle of a step
        step(0, 1, 16'h0100, 0);
        step(0, 0, '0, 1);
        step(0, 0, '0, 0);
        #2 reset = 1'b1;
        #1;
        chk("async_busy", 32'(bus.o_busy), 32'd0);
        chk("async_armed", 32'(bus.o_armed), 32'd0);
        chk("async_count", 32'(bus.o_count), 32'd0);
        chk("async_expire", 32'(bus.o_expire), 32'd0);
        chk("async_drop", 32'(bus.o_tick_drop), 32'd0);
        chk("async_ready", 32'(bus.o_load_ready), 32'd1);
        model_reset();
        @(negedge clk);
        chk("async_hold_expire", 32'(bus.o_expire), 32'd0);
        reset = 1'b0;
        busy_n = 0; drop_n = 0; exp_n = 0;
        step(0, 1, 16'h0002, 0);
        step(0, 0, '0, 1);
        repeat (3) step(0, 0, '0, 0);
        chk("after_reset_first_tick_expires", exp_n, 0);
        chk("after_reset_count1", 32'(bus.o_count), 32'h0001);
        step(0, 0, '0, 1);
        repeat (2) step(0, 0, '0, 0);
        chk("after_reset_second_tick_expires", exp_n, 1);
        chk("after_reset_count0", 32'(bus.o_count), 32'h0000);

        // random traffic against the model
        for (int n = 0; n < 800; n++) begin
            logic [W-1:0] v;
            bit a, lv, t;
            v = '0;
            for (int k = 0; k < int'(NIBBLES); k++)
                if ($urandom_range(0, 1) == 1) v[4*k +: 4] = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 40) == 0);
            lv = ($urandom_range(0, 7) == 0);
            t  = ($urandom_range(0, 2) != 0);
            step(a, lv, v, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
